// File: rtl/booth_product_accumulator_if.sv
// Handshake bundle between the Booth multiplier, the accumulator and the result consumer.
interface booth_product_accumulator_if #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 8
);
    logic [7:0]       prod;
    logic             prod_valid;
    logic             prod_ready;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;
    logic             acc_ovf;
    logic [CNT_W-1:0] frame_cnt;

    // Accumulator side
    modport slave (
        input  prod, prod_valid, acc_ready,
        output prod_ready, acc_out, acc_valid, acc_ovf, frame_cnt
    );

    // Producer/consumer side
    modport master (
        output prod, prod_valid, acc_ready,
        input  prod_ready, acc_out, acc_valid, acc_ovf, frame_cnt
    );
endinterface

// File: rtl/booth_product_accumulator.sv
// Frame accumulator: sums FRAME_LEN signed 8-bit products into an ACC_W-bit
// wrapping accumulator, then holds the sum plus a sticky overflow flag until
// the consumer takes it.
module booth_product_accumulator #(
    parameter int ACC_W     = 12,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    booth_product_accumulator_if.slave bus
);
    typedef enum logic {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             ovf_add;
    logic             accept;

    assign prod_ext = ACC_W'($signed(bus.prod));
    assign sum      = acc_q + prod_ext;
    // Signed overflow: operands agree in sign, result does not.
    assign ovf_add  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_q[ACC_W-1]);
    assign accept   = bus.prod_valid & bus.prod_ready;

    // State and datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: clear aborts the frame and discards any coincident handshake.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        acc_d = sum;
                        ovf_d = ovf_q | ovf_add;
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = ST_HOLD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.acc_ready) begin
                        state_d = ST_ACCUM;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    // Outputs decoded from registered state only, so no input-to-output path.
    always_comb begin
        bus.prod_ready = (state_q == ST_ACCUM);
        bus.acc_valid  = (state_q == ST_HOLD);
        bus.acc_out    = acc_q;
        bus.acc_ovf    = ovf_q;
        bus.frame_cnt  = cnt_q;
    end
endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench for the product accumulator: three configurations, a
// cycle-level reference model and a per-instance result scoreboard.
module tb_booth_product_accumulator;
    typedef struct {
        int acc;
        int ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clr0, clr1, clr2;

    always #5 clk = ~clk;

    booth_product_accumulator_if #(.ACC_W(12), .CNT_W(8)) b0 ();
    booth_product_accumulator_if #(.ACC_W(8),  .CNT_W(8)) b1 ();
    booth_product_accumulator_if #(.ACC_W(12), .CNT_W(8)) b2 ();

    booth_product_accumulator #(.ACC_W(12), .FRAME_LEN(4), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clr0), .bus(b0));
    booth_product_accumulator #(.ACC_W(8),  .FRAME_LEN(4), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clr1), .bus(b1));
    booth_product_accumulator #(.ACC_W(12), .FRAME_LEN(1), .CNT_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clr2), .bus(b2));

    int checks = 0;
    int fails  = 0;

    // Reference model state per instance
    int   W[3] = '{12, 8, 12};
    int   L[3] = '{4, 4, 1};
    int   m_acc[3];
    int   m_cnt[3];
    int   m_hold[3];
    int   m_ovf[3];
    exp_t sb[3][$];

    // Last observed outputs of the instance under test
    int o_rdy, o_vld, o_acc, o_ovf, o_cnt;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mstep(input int k, input bit c, input bit pv, input logic [7:0] p, input bit ar);
        int mask;
        int sp;
        int s;
        exp_t e;
        mask = (1 << W[k]) - 1;
        sp   = int'($signed(p));
        if (!rst_n) begin
            for (int j = 0; j < 3; j++) begin
                m_acc[j] = 0; m_cnt[j] = 0; m_hold[j] = 0; m_ovf[j] = 0;
                sb[j].delete();
            end
        end else if (c) begin
            if (m_hold[k] != 0) void'(sb[k].pop_front());
            m_acc[k] = 0; m_cnt[k] = 0; m_hold[k] = 0; m_ovf[k] = 0;
        end else if (m_hold[k] != 0) begin
            if (ar) begin
                void'(sb[k].pop_front());
                m_acc[k] = 0; m_cnt[k] = 0; m_hold[k] = 0; m_ovf[k] = 0;
            end
        end else if (pv) begin
            s = (m_acc[k] + sp) & mask;
            if ((((m_acc[k] >> (W[k]-1)) & 1) == int'(p[7])) &&
                (((s >> (W[k]-1)) & 1) != int'(p[7])))
                m_ovf[k] = 1;
            m_acc[k] = s;
            if (m_cnt[k] == L[k] - 1) begin
                m_cnt[k]  = 0;
                m_hold[k] = 1;
                e.acc = s;
                e.ovf = m_ovf[k];
                sb[k].push_back(e);
            end else begin
                m_cnt[k]++;
            end
        end
    endtask

    task automatic sample(input int k);
        case (k)
            0: begin o_rdy = int'(b0.prod_ready); o_vld = int'(b0.acc_valid);
                     o_acc = int'(b0.acc_out); o_ovf = int'(b0.acc_ovf); o_cnt = int'(b0.frame_cnt); end
            1: begin o_rdy = int'(b1.prod_ready); o_vld = int'(b1.acc_valid);
                     o_acc = int'(b1.acc_out); o_ovf = int'(b1.acc_ovf); o_cnt = int'(b1.frame_cnt); end
            default: begin o_rdy = int'(b2.prod_ready); o_vld = int'(b2.acc_valid);
                     o_acc = int'(b2.acc_out); o_ovf = int'(b2.acc_ovf); o_cnt = int'(b2.frame_cnt); end
        endcase
    endtask

    // One clock for instance k; the others idle. Inputs change and outputs
    // are sampled on the falling edge.
    task automatic drive(input int k, input bit c, input bit pv, input logic [7:0] p, input bit ar);
        b0.prod_valid = 1'b0; b0.prod = '0; b0.acc_ready = 1'b0; clr0 = 1'b0;
        b1.prod_valid = 1'b0; b1.prod = '0; b1.acc_ready = 1'b0; clr1 = 1'b0;
        b2.prod_valid = 1'b0; b2.prod = '0; b2.acc_ready = 1'b0; clr2 = 1'b0;
        case (k)
            0: begin b0.prod_valid = pv; b0.prod = p; b0.acc_ready = ar; clr0 = c; end
            1: begin b1.prod_valid = pv; b1.prod = p; b1.acc_ready = ar; clr1 = c; end
            default: begin b2.prod_valid = pv; b2.prod = p; b2.acc_ready = ar; clr2 = c; end
        endcase
        @(posedge clk);
        mstep(k, c, pv, p, ar);
        @(negedge clk);
        sample(k);
        chk("prod_ready", o_rdy, (m_hold[k] != 0) ? 0 : 1);
        chk("acc_valid", o_vld, m_hold[k]);
        chk("frame_cnt", o_cnt, m_cnt[k]);
        chk("acc_reg", o_acc, m_acc[k]);
        if (m_hold[k] != 0 && sb[k].size() > 0) begin
            chk("sb_acc", o_acc, sb[k][0].acc);
            chk("sb_ovf", o_ovf, sb[k][0].ovf);
        end
    endtask

    task automatic put(input int k, input logic [7:0] p, input bit ar);
        drive(k, 1'b0, 1'b1, p, ar);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
        @(negedge clk);
        do_reset();
        chk("rst_acc", o_acc, 0);
        chk("rst_ovf", o_ovf, 0);
        chk("rst_rdy", o_rdy, 1);

        // Basic frame, consumer always ready
        put(0, 8'h03, 1'b1); put(0, 8'hFB, 1'b1); put(0, 8'h0A, 1'b1); put(0, 8'hFF, 1'b1);
        chk("f1_valid", o_vld, 1);
        chk("f1_acc", o_acc, 'h007);
        chk("f1_ovf", o_ovf, 0);
        drive(0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("f1_rdy_back", o_rdy, 1);

        // Backpressure with upstream stalled on 0x11
        put(0, 8'h03, 1'b0); put(0, 8'hFB, 1'b0); put(0, 8'h0A, 1'b0); put(0, 8'hFF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            put(0, 8'h11, 1'b0);
            chk("bp_hold_acc", o_acc, 'h007);
        end
        put(0, 8'h11, 1'b1);
        chk("bp_released_cnt", o_cnt, 0);
        put(0, 8'h11, 1'b0);
        chk("bp_first_acc", o_acc, 'h011);
        chk("bp_first_cnt", o_cnt, 1);
        put(0, 8'h01, 1'b0); put(0, 8'h01, 1'b0); put(0, 8'h01, 1'b0);
        chk("bp_next_acc", o_acc, 'h014);
        drive(0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Clear coincident with third accept
        put(0, 8'h05, 1'b0); put(0, 8'h05, 1'b0);
        drive(0, 1'b1, 1'b1, 8'h05, 1'b0);
        chk("clr_cnt", o_cnt, 0);
        chk("clr_acc", o_acc, 0);
        put(0, 8'h02, 1'b0); put(0, 8'h02, 1'b0); put(0, 8'h02, 1'b0); put(0, 8'h02, 1'b0);
        chk("clr_next_acc", o_acc, 'h008);
        drive(0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Clear in HOLD together with acc_ready
        put(0, 8'h01, 1'b0); put(0, 8'h01, 1'b0); put(0, 8'h01, 1'b0); put(0, 8'h01, 1'b0);
        drive(0, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("clrh_valid", o_vld, 0);
        chk("clrh_cnt", o_cnt, 0);
        chk("clrh_rdy", o_rdy, 1);

        // Reset mid-frame
        put(0, 8'h07, 1'b0); put(0, 8'h07, 1'b0);
        do_reset();
        chk("rstm_cnt", o_cnt, 0);
        chk("rstm_acc", o_acc, 0);
        put(0, 8'h01, 1'b0); put(0, 8'h01, 1'b0); put(0, 8'h01, 1'b0); put(0, 8'h01, 1'b0);
        chk("rstm_next_acc", o_acc, 'h004);
        drive(0, 1'b0, 1'b0, 8'h00, 1'b1);

        // 8-bit accumulator: 100+100 overflows, then -128 overflows back to 72
        put(1, 8'h64, 1'b0); put(1, 8'h64, 1'b0); put(1, 8'h80, 1'b0); put(1, 8'h00, 1'b0);
        chk("w8_acc", o_acc, 'h48);
        chk("w8_ovf", o_ovf, 1);
        drive(1, 1'b0, 1'b0, 8'h00, 1'b1);
        put(1, 8'h01, 1'b0); put(1, 8'h01, 1'b0); put(1, 8'h01, 1'b0); put(1, 8'h01, 1'b0);
        chk("w8_next_acc", o_acc, 'h04);
        chk("w8_next_ovf", o_ovf, 0);
        drive(1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Single-product frames
        put(2, 8'h80, 1'b0);
        chk("f1len_valid", o_vld, 1);
        chk("f1len_acc", o_acc, 'hF80);
        drive(2, 1'b0, 1'b0, 8'h00, 1'b1);
        put(2, 8'h7F, 1'b1);
        chk("f1len_acc2", o_acc, 'h07F);
        drive(2, 1'b0, 1'b0, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
